// File: rtl/id_ex_operand_stage_if.sv
// Decode/regfile/EX/MEM signal bundle for id_ex_operand_stage.
// The slave modport is the stage itself; the master modport is whatever drives it.
interface id_ex_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rs1;
  logic [RADDR_W-1:0] in_rs2;
  logic               in_use_rs1;
  logic               in_use_rs2;
  logic [RADDR_W-1:0] in_rd;
  logic               in_rd_we;
  logic               in_is_load;
  logic [XLEN-1:0]    in_pc;
  logic [RADDR_W-1:0] rf_src_a;
  logic [RADDR_W-1:0] rf_src_b;
  logic [XLEN-1:0]    rf_reg_a;
  logic [XLEN-1:0]    rf_reg_b;
  logic [XLEN-1:0]    ex_result;
  logic               mem_valid;
  logic               mem_rd_we;
  logic [RADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]    mem_result;
  logic               ex_stall;
  logic               flush;
  logic               out_valid;
  logic [XLEN-1:0]    out_rs1_val;
  logic [XLEN-1:0]    out_rs2_val;
  logic [RADDR_W-1:0] out_rd;
  logic               out_rd_we;
  logic               out_is_load;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        perf_load_use_cnt;
  logic [31:0]        perf_flush_cnt;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_we,
           in_is_load, in_pc, rf_reg_a, rf_reg_b, ex_result, mem_valid,
           mem_rd_we, mem_rd, mem_result, ex_stall, flush,
    output in_ready, rf_src_a, rf_src_b, out_valid, out_rs1_val, out_rs2_val,
           out_rd, out_rd_we, out_is_load, out_pc, perf_load_use_cnt, perf_flush_cnt
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_we,
           in_is_load, in_pc, rf_reg_a, rf_reg_b, ex_result, mem_valid,
           mem_rd_we, mem_rd, mem_result, ex_stall, flush,
    input  in_ready, rf_src_a, rf_src_b, out_valid, out_rs1_val, out_rs2_val,
           out_rd, out_rd_we, out_is_load, out_pc, perf_load_use_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: EX/MEM forwarding, load-use bubble, ID/EX pipeline register.
// Optional HAZARD_PERF_EN macro adds load-use and flush event counters.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave io_bus
);
  logic               w_load_use;
  logic               w_ex_fwd;
  logic               w_mem_fwd;
  logic [XLEN-1:0]    w_op_a;
  logic [XLEN-1:0]    w_op_b;
  logic               r_valid;
  logic               r_rd_we;
  logic               r_is_load;
  logic [RADDR_W-1:0] r_rd;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_rs1_val;
  logic [XLEN-1:0]    r_rs2_val;

  // x0 is hardwired; the younger EX producer beats the older MEM producer.
  function automatic logic [XLEN-1:0] f_select(
      input logic [RADDR_W-1:0] idx,
      input logic [XLEN-1:0]    rf_val,
      input logic               ex_fwd,
      input logic [RADDR_W-1:0] ex_rd,
      input logic [XLEN-1:0]    ex_val,
      input logic               mem_fwd,
      input logic [RADDR_W-1:0] mem_rd,
      input logic [XLEN-1:0]    mem_val
  );
    logic [XLEN-1:0] v;
    if (idx == {RADDR_W{1'b0}}) begin
      v = {XLEN{1'b0}};
    end else if (ex_fwd && (ex_rd == idx)) begin
      v = ex_val;
    end else if (mem_fwd && (mem_rd == idx)) begin
      v = mem_val;
    end else begin
      v = rf_val;
    end
    return v;
  endfunction

  // Hazard detection, operand resolution and decode handshake.
  always_comb begin
    w_ex_fwd   = r_valid & r_rd_we & ~r_is_load;
    w_mem_fwd  = io_bus.mem_valid & io_bus.mem_rd_we;
    w_load_use = io_bus.in_valid & r_valid & r_is_load & r_rd_we &
                 (r_rd != {RADDR_W{1'b0}}) &
                 ((io_bus.in_use_rs1 & (io_bus.in_rs1 == r_rd)) |
                  (io_bus.in_use_rs2 & (io_bus.in_rs2 == r_rd)));
    w_op_a = f_select(io_bus.in_rs1, io_bus.rf_reg_a, w_ex_fwd, r_rd, io_bus.ex_result,
                      w_mem_fwd, io_bus.mem_rd, io_bus.mem_result);
    w_op_b = f_select(io_bus.in_rs2, io_bus.rf_reg_b, w_ex_fwd, r_rd, io_bus.ex_result,
                      w_mem_fwd, io_bus.mem_rd, io_bus.mem_result);
  end

  assign io_bus.in_ready = ~io_bus.ex_stall & ~w_load_use;
  assign io_bus.rf_src_a = io_bus.in_rs1;
  assign io_bus.rf_src_b = io_bus.in_rs2;

  // ID/EX register: flush beats stall, stall beats the load-use bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_rd_we   <= 1'b0;
      r_is_load <= 1'b0;
      r_rd      <= {RADDR_W{1'b0}};
      r_pc      <= {XLEN{1'b0}};
      r_rs1_val <= {XLEN{1'b0}};
      r_rs2_val <= {XLEN{1'b0}};
    end else if (io_bus.flush) begin
      r_valid <= 1'b0;
    end else if (!io_bus.ex_stall) begin
      if (w_load_use) begin
        r_valid <= 1'b0;
      end else begin
        r_valid   <= io_bus.in_valid;
        r_rd_we   <= io_bus.in_rd_we;
        r_is_load <= io_bus.in_is_load;
        r_rd      <= io_bus.in_rd;
        r_pc      <= io_bus.in_pc;
        r_rs1_val <= w_op_a;
        r_rs2_val <= w_op_b;
      end
    end
  end

  assign io_bus.out_valid   = r_valid;
  assign io_bus.out_rd_we   = r_rd_we;
  assign io_bus.out_is_load = r_is_load;
  assign io_bus.out_rd      = r_rd;
  assign io_bus.out_pc      = r_pc;
  assign io_bus.out_rs1_val = r_rs1_val;
  assign io_bus.out_rs2_val = r_rs2_val;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_lu_cnt;
  logic [31:0] r_fl_cnt;

  // Event counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_cnt <= 32'd0;
      r_fl_cnt <= 32'd0;
    end else begin
      if (!io_bus.flush && !io_bus.ex_stall && w_load_use) begin
        r_lu_cnt <= r_lu_cnt + 32'd1;
      end
      if (io_bus.flush && r_valid) begin
        r_fl_cnt <= r_fl_cnt + 32'd1;
      end
    end
  end

  assign io_bus.perf_load_use_cnt = r_lu_cnt;
  assign io_bus.perf_flush_cnt    = r_fl_cnt;
`else
  assign io_bus.perf_load_use_cnt = 32'd0;
  assign io_bus.perf_flush_cnt    = 32'd0;
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized scoreboard bench for id_ex_operand_stage with an in-bench reference model.
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();
  id_ex_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] v;
  } prod_t;

  typedef struct packed {
    logic        k;
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] plu;
    logic [31:0] pfl;
  } exp_t;

  exp_t q[$];

  // Reference EX slot: what the stage is architecturally holding.
  logic        m_valid = 1'b0, m_known = 1'b0, m_we = 1'b0, m_ld = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_pc = 32'd0, m_a = 32'd0, m_b = 32'd0, m_lu = 32'd0, m_fl = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest producer first: the instruction in EX, then the one in MEM.
  function automatic logic [31:0] m_op(input logic [4:0] idx, input logic [31:0] rfv);
    prod_t pl[$];
    prod_t p;
    if (m_valid && m_we && !m_ld) begin
      p.rd = m_rd; p.v = bus.ex_result; pl.push_back(p);
    end
    if (bus.mem_valid && bus.mem_rd_we) begin
      p.rd = bus.mem_rd; p.v = bus.mem_result; pl.push_back(p);
    end
    if (idx == 5'd0) return 32'd0;
    foreach (pl[k]) if (pl[k].rd == idx) return pl[k].v;
    return rfv;
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0; bus.in_rd = 5'd0;
    bus.in_rd_we = 1'b0; bus.in_is_load = 1'b0; bus.in_pc = 32'd0;
    bus.rf_reg_a = 32'd0; bus.rf_reg_b = 32'd0; bus.ex_result = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_rd_we = 1'b0; bus.mem_rd = 5'd0;
    bus.mem_result = 32'd0; bus.ex_stall = 1'b0; bus.flush = 1'b0;
  endtask

  // Check combinational outputs, advance the model one clock, queue the expectation.
  task automatic step();
    logic        lu;
    logic [31:0] na, nb;
    exp_t        e;
    #1;
    lu = bus.in_valid && m_valid && m_ld && m_we && (m_rd != 5'd0) &&
         ((bus.in_use_rs1 && bus.in_rs1 == m_rd) || (bus.in_use_rs2 && bus.in_rs2 == m_rd));
    na = m_op(bus.in_rs1, bus.rf_reg_a);
    nb = m_op(bus.in_rs2, bus.rf_reg_b);
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.ex_stall && !lu));
      chk("rf_src", {22'd0, bus.rf_src_b, bus.rf_src_a}, {22'd0, bus.in_rs2, bus.in_rs1});
    end
    if (rst) begin
      m_valid = 1'b0; m_known = 1'b1; m_we = 1'b0; m_ld = 1'b0; m_rd = 5'd0;
      m_pc = 32'd0; m_a = 32'd0; m_b = 32'd0; m_lu = 32'd0; m_fl = 32'd0;
    end else begin
      if (bus.flush && m_valid) m_fl = m_fl + 32'd1;
      if (bus.flush) begin
        m_valid = 1'b0; m_known = 1'b0;
      end else if (!bus.ex_stall) begin
        if (lu) begin
          m_valid = 1'b0; m_known = 1'b0; m_lu = m_lu + 32'd1;
        end else begin
          m_valid = bus.in_valid; m_known = 1'b1; m_we = bus.in_rd_we;
          m_ld = bus.in_is_load; m_rd = bus.in_rd; m_pc = bus.in_pc; m_a = na; m_b = nb;
        end
      end
    end
    e.k = m_known; e.v = m_valid; e.rd = m_rd; e.we = m_we; e.ld = m_ld;
    e.pc = m_pc; e.a = m_a; e.b = m_b;
`ifdef HAZARD_PERF_EN
    e.plu = m_lu; e.pfl = m_fl;
`else
    e.plu = 32'd0; e.pfl = 32'd0;
`endif
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per clock and compares the registered outputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'(e.v));
      chk("perf_lu", bus.perf_load_use_cnt, e.plu);
      chk("perf_fl", bus.perf_flush_cnt, e.pfl);
      if (e.k) begin
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
        chk("out_flags", {30'd0, bus.out_rd_we, bus.out_is_load}, {30'd0, e.we, e.ld});
        chk("out_pc", bus.out_pc, e.pc);
        chk("out_rs1_val", bus.out_rs1_val, e.a);
        chk("out_rs2_val", bus.out_rs2_val, e.b);
      end
    end
  end

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld, input logic [31:0] pc);
    idle();
    bus.in_valid = 1'b1; bus.in_rd = rd; bus.in_rd_we = we; bus.in_is_load = ld; bus.in_pc = pc;
    step();
  endtask

  initial begin
    logic [31:0] held_pc;
    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    rst = 1'b0;

    // EX forwarding beats regfile data.
    issue(5'd5, 1'b1, 1'b0, 32'h100);
    idle(); bus.in_valid = 1'b1; bus.in_use_rs1 = 1'b1; bus.in_rs1 = 5'd5;
    bus.ex_result = 32'h10; bus.rf_reg_a = 32'h99;
    step();
    chk("ex_fwd", bus.out_rs1_val, 32'h10);

    // Load-use: one bubble, then the load value arrives from MEM.
    issue(5'd7, 1'b1, 1'b1, 32'h200);
    idle(); bus.in_valid = 1'b1; bus.in_use_rs2 = 1'b1; bus.in_rs2 = 5'd7; bus.in_pc = 32'h204;
    #1 chk("lu_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(bus.out_valid), 32'd0);
    bus.mem_valid = 1'b1; bus.mem_rd_we = 1'b1; bus.mem_rd = 5'd7; bus.mem_result = 32'hABCD;
    step();
    chk("mem_fwd", bus.out_rs2_val, 32'hABCD);

    // x0 never forwards.
    issue(5'd0, 1'b1, 1'b0, 32'h300);
    idle(); bus.in_valid = 1'b1; bus.in_use_rs1 = 1'b1; bus.ex_result = 32'hFF;
    bus.mem_valid = 1'b1; bus.mem_rd_we = 1'b1; bus.mem_result = 32'hFF; bus.rf_reg_a = 32'hFF;
    step();
    chk("x0_zero", bus.out_rs1_val, 32'd0);

    // EX has priority over MEM for the same register.
    issue(5'd3, 1'b1, 1'b0, 32'h400);
    idle(); bus.in_valid = 1'b1; bus.in_use_rs1 = 1'b1; bus.in_rs1 = 5'd3;
    bus.ex_result = 32'h1; bus.mem_valid = 1'b1; bus.mem_rd_we = 1'b1;
    bus.mem_rd = 5'd3; bus.mem_result = 32'h2;
    step();
    chk("ex_prio", bus.out_rs1_val, 32'h1);

    // Stall holds for three cycles, then flush wins over stall.
    issue(5'd9, 1'b1, 1'b0, 32'h500);
    held_pc = 32'h500;
    for (int i = 0; i < 3; i++) begin
      idle(); bus.in_valid = 1'b1; bus.in_pc = $urandom; bus.ex_stall = 1'b1;
      step();
    end
    chk("stall_hold", bus.out_pc, held_pc);
    bus.flush = 1'b1;
    step();
    chk("flush_stall", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a stalled load-use hazard.
    issue(5'd4, 1'b1, 1'b1, 32'h600);
    idle(); bus.in_valid = 1'b1; bus.in_use_rs1 = 1'b1; bus.in_rs1 = 5'd4; bus.ex_stall = 1'b1;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    bus.ex_stall = 1'b0;
    #1 chk("rst_clears_hazard", 32'(bus.in_ready), 32'd1);
    step();

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 3) != 0);
      bus.in_rs1     = 5'($urandom_range(0, 7));
      bus.in_rs2     = 5'($urandom_range(0, 7));
      bus.in_use_rs1 = 1'($urandom_range(0, 1));
      bus.in_use_rs2 = 1'($urandom_range(0, 1));
      bus.in_rd      = 5'($urandom_range(0, 7));
      bus.in_rd_we   = 1'($urandom_range(0, 3) != 0);
      bus.in_is_load = 1'($urandom_range(0, 2) == 0);
      bus.in_pc      = $urandom;
      bus.rf_reg_a   = $urandom;
      bus.rf_reg_b   = $urandom;
      bus.ex_result  = $urandom;
      bus.mem_valid  = 1'($urandom_range(0, 1));
      bus.mem_rd_we  = 1'($urandom_range(0, 1));
      bus.mem_rd     = 5'($urandom_range(0, 7));
      bus.mem_result = $urandom;
      bus.ex_stall   = 1'($urandom_range(0, 4) == 0);
      bus.flush      = 1'($urandom_range(0, 11) == 0);
      rst            = 1'($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
